seg7_multi_display: RTL and testbench

//  Multi-digit 7-segment display controller for the DE1-SoC HEX bank.

---
 rtl/seg7_multi_display.sv | 217 +++++++++++++++++++++
 tb/tb_seg7_multi_display.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_multi_display.sv
// seg7_multi_display
//   Multi-digit 7-segment controller for the DE1-SoC HEX bank. A binary value
//   is accepted through a valid/ready handshake and shown in hex or decimal.
//   Decimal values pass through a sequential double-dabble converter, one bit
//   per cycle. The block supports per-digit decimal points, leading-zero
//   blanking, an overflow indication (all digits show a dash) and whole-display
//   blinking.
//
// Ports
//   clk          system clock, single domain
//   rst          synchronous reset, active-high
//   in_valid     in_data/in_dec/in_blank_lz/in_dots are valid
//   in_ready     block can accept a new value (high only in IDLE)
//   in_data      unsigned value to display
//   in_dec       1 = decimal, 0 = hex
//   in_blank_lz  1 = blank leading zero digits (digit 0 is never blanked)
//   in_dots      decimal point per digit, 1 = lit
//   blink_en     1 = whole display blinks (live input, not captured)
//   busy         conversion in progress (= ~in_ready)
//   overflow     last displayed value did not fit in NUM_DIGITS digits
//   seg_out      digit k = seg_out[8k+7:8k], active-low, bit7 = dp,
//                [6:0] = {g,f,e,d,c,b,a}
//
// Handshake: a transfer happens on a rising edge where in_valid && in_ready.
//   in_ready depends only on the FSM state, never on in_valid. in_valid seen
//   while in_ready is low is ignored; nothing is queued.
//
// The FSM state register is named `state` (IDLE/CONV/LOAD) so checkers can
// bind to it directly.

module seg7_multi_display #(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 24,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_dec,
  input  logic                    in_blank_lz,
  input  logic [NUM_DIGITS-1:0]   in_dots,
  input  logic                    blink_en,
  output logic                    busy,
  output logic                    overflow,
  output logic [8*NUM_DIGITS-1:0] seg_out
);

  localparam int SW  = 8 * NUM_DIGITS;
  // One extra BCD digit above the displayed ones catches decimal overflow.
  localparam int BW  = 4 * NUM_DIGITS + 4;
  localparam int HW  = (DATA_W > 4 * NUM_DIGITS) ? DATA_W : 4 * NUM_DIGITS;
  localparam int CW  = $clog2(DATA_W + 1);
  localparam int BCW = $clog2(BLINK_DIV);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  logic [1:0]            state;

  // Captured request fields
  logic [DATA_W-1:0]     data_r;
  logic                  dec_r;
  logic                  blank_r;
  logic [NUM_DIGITS-1:0] dots_r;

  // Double-dabble datapath
  logic [BW-1:0]         bcd;
  logic [BW-1:0]         bcd_adj;
  logic [DATA_W-1:0]     sh;
  logic                  dd_sticky;
  logic [CW-1:0]         cnt;

  // Display registers
  logic [SW-1:0]         seg_reg;
  logic [SW-1:0]         load_seg;
  logic                  load_ovf;
  logic                  hex_ovf;
  logic [HW-1:0]         hex_ext;

  // Blink
  logic [BCW-1:0]        blink_cnt;
  logic                  blink_phase;

  // Per-digit scratch used by the LOAD glyph builder
  logic [3:0]            dig;
  logic [6:0]            gly;
  logic                  nz_seen;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h18;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;

  assign hex_ext = HW'(data_r);

  // Hex overflow only exists when in_data is wider than the displayed digits.
  generate
    if (DATA_W > 4 * NUM_DIGITS) begin : g_hex_ovf
      assign hex_ovf = |data_r[DATA_W-1:4*NUM_DIGITS];
    end else begin : g_no_hex_ovf
      assign hex_ovf = 1'b0;
    end
  endgenerate

  // Add-3 correction applied before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BW / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Glyph builder for LOAD. Walks from the top digit down so nz_seen tells
  // whether any more-significant digit (or this one) is nonzero.
  always_comb begin
    load_ovf = dec_r ? (dd_sticky | (bcd[BW-1 -: 4] != 4'd0)) : hex_ovf;
    load_seg = '1;
    nz_seen  = 1'b0;
    dig      = 4'd0;
    gly      = 7'h7F;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      dig     = dec_r ? bcd[4*k +: 4] : hex_ext[4*k +: 4];
      nz_seen = nz_seen | (dig != 4'd0);
      if (load_ovf)                            gly = 7'h3F;
      else if (blank_r && !nz_seen && k != 0)  gly = 7'h7F;
      else                                     gly = glyph(dig);
      load_seg[8*k +: 8] = {~dots_r[k], gly};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_r    <= '0;
      dec_r     <= 1'b0;
      blank_r   <= 1'b0;
      dots_r    <= '0;
      bcd       <= '0;
      sh        <= '0;
      dd_sticky <= 1'b0;
      cnt       <= '0;
      seg_reg   <= '1;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_r    <= in_data;
            dec_r     <= in_dec;
            blank_r   <= in_blank_lz;
            dots_r    <= in_dots;
            bcd       <= '0;
            sh        <= in_data;
            dd_sticky <= 1'b0;
            cnt       <= '0;
            state     <= in_dec ? CONV : LOAD;
          end
        end
        CONV: begin
          bcd       <= {bcd_adj[BW-2:0], sh[DATA_W-1]};
          sh        <= sh << 1;
          // A carry out of the extra digit means the value is far too large;
          // remember it since the BCD register alone would wrap.
          dd_sticky <= dd_sticky | bcd_adj[BW-1];
          cnt       <= cnt + 1'b1;
          if (cnt == CW'(DATA_W - 1)) state <= LOAD;
        end
        LOAD: begin
          seg_reg  <= load_seg;
          overflow <= load_ovf;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running blink timebase, independent of the display FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // Blanking during the off phase is purely combinational, so the captured
  // content reappears unchanged in the next on phase.
  assign seg_out = (blink_en && blink_phase) ? '1 : seg_reg;

endmodule

// File: tb/tb_seg7_multi_display.sv
module tb_seg7_multi_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        in_dec;
  logic        in_blank_lz;
  logic [5:0]  in_dots;
  logic        blink_en;
  logic        busy;
  logic        overflow;
  logic [47:0] seg_out;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  seg7_multi_display #(
    .NUM_DIGITS(6),
    .DATA_W(24),
    .BLINK_DIV(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_dec(in_dec),
    .in_blank_lz(in_blank_lz),
    .in_dots(in_dots),
    .blink_en(blink_en),
    .busy(busy),
    .overflow(overflow),
    .seg_out(seg_out)
  );

  // ---------------- driver ----------------
  // Drives one request on a negedge, then counts negedge samples with
  // in_ready low. Returns sitting on the first sample with in_ready high.
  task automatic send(input logic [23:0] d, input logic dec, input logic blz,
                      input logic [5:0] dots, output int lows);
    @(negedge clk);
    in_valid    = 1'b1;
    in_data     = d;
    in_dec      = dec;
    in_blank_lz = blz;
    in_dots     = dots;
    @(negedge clk);
    in_valid = 1'b0;
    lows = 0;
    while (in_ready !== 1'b1 && lows < 100) begin
      lows++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (seg_out !== 48'hFFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL reset_seg got=%h exp=%h", seg_out, 48'hFFFF_FFFF_FFFF);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_hex_beef();
    int lows;
    send(24'h00BEEF, 1'b0, 1'b0, 6'b000000, lows);
    n_tests++;
    if (lows !== 1) begin n_fail++; $display("FAIL hex_latency got=%0d exp=1", lows); end
    n_tests++;
    if (seg_out !== 48'hC0C0_8386_868E) begin
      n_fail++; $display("FAIL hex_beef got=%h exp=%h", seg_out, 48'hC0C0_8386_868E);
    end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL hex_beef_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_dec_123456();
    int lows;
    send(24'd123456, 1'b1, 1'b0, 6'b000100, lows);
    n_tests++;
    if (lows !== 25) begin n_fail++; $display("FAIL dec_latency got=%0d exp=25", lows); end
    n_tests++;
    if (seg_out !== 48'hF9A4_B019_9282) begin
      n_fail++; $display("FAIL dec_123456 got=%h exp=%h", seg_out, 48'hF9A4_B019_9282);
    end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL dec_123456_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_dec_overflow();
    int lows;
    send(24'd1000000, 1'b1, 1'b0, 6'b000000, lows);
    n_tests++;
    if (seg_out !== 48'hBFBF_BFBF_BFBF) begin
      n_fail++; $display("FAIL dec_ovf_seg got=%h exp=%h", seg_out, 48'hBFBF_BFBF_BFBF);
    end
    n_tests++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL dec_ovf_flag got=%b exp=1", overflow); end
    send(24'd0, 1'b1, 1'b1, 6'b000000, lows);
    n_tests++;
    if (seg_out !== 48'hFFFF_FFFF_FFC0) begin
      n_fail++; $display("FAIL dec_zero_blank got=%h exp=%h", seg_out, 48'hFFFF_FFFF_FFC0);
    end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL dec_zero_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_dec_boundary();
    int lows;
    send(24'd999999, 1'b1, 1'b1, 6'b000000, lows);
    n_tests++;
    if (seg_out !== 48'h9898_9898_9898) begin
      n_fail++; $display("FAIL dec_999999 got=%h exp=%h", seg_out, 48'h9898_9898_9898);
    end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL dec_999999_ovf got=%b exp=0", overflow); end
    // 16777215 has eight decimal digits: overflows even the extra BCD digit.
    send(24'hFFFFFF, 1'b1, 1'b0, 6'b100001, lows);
    n_tests++;
    if (seg_out !== 48'h3FBF_BFBF_BF3F) begin
      n_fail++; $display("FAIL dec_max got=%h exp=%h", seg_out, 48'h3FBF_BFBF_BF3F);
    end
    n_tests++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL dec_max_ovf got=%b exp=1", overflow); end
  endtask

  task automatic test_hex_blank();
    int lows;
    // 0xA0 with blanking; dp on blanked digit 4 stays lit.
    send(24'h0000A0, 1'b0, 1'b1, 6'b010000, lows);
    n_tests++;
    if (seg_out !== 48'hFF7F_FFFF_88C0) begin
      n_fail++; $display("FAIL hex_blank got=%h exp=%h", seg_out, 48'hFF7F_FFFF_88C0);
    end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL hex_blank_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_blink(input logic [47:0] content);
    int waited;
    logic [47:0] exp_v;
    blink_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (seg_out !== content) begin
        n_fail++; $display("FAIL blink_off_steady[%0d] got=%h exp=%h", i, seg_out, content);
      end
    end
    blink_en = 1'b1;
    waited = 0;
    @(negedge clk);
    while (seg_out !== content && waited < 20) begin @(negedge clk); waited++; end
    while (seg_out === content && waited < 20) begin @(negedge clk); waited++; end
    n_tests++;
    if (waited >= 20) begin n_fail++; $display("FAIL blink_find got=timeout exp=phase_edge"); end
    // Now on the first dark sample: 4 dark, 4 lit, 4 dark.
    for (int i = 0; i < 12; i++) begin
      exp_v = (i >= 4 && i < 8) ? content : 48'hFFFF_FFFF_FFFF;
      n_tests++;
      if (seg_out !== exp_v) begin
        n_fail++; $display("FAIL blink_cycle[%0d] got=%h exp=%h", i, seg_out, exp_v);
      end
      @(negedge clk);
    end
    blink_en = 1'b0;
  endtask

  task automatic test_reset_mid_conv();
    @(negedge clk);
    in_valid    = 1'b1;
    in_data     = 24'd123456;
    in_dec      = 1'b1;
    in_blank_lz = 1'b0;
    in_dots     = 6'b000000;
    @(negedge clk);
    // in_valid held with other data during CONV must be ignored.
    in_data = 24'd654321;
    repeat (5) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midconv_busy got=%b exp=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (seg_out !== 48'hFFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL midconv_rst_seg got=%h exp=%h", seg_out, 48'hFFFF_FFFF_FFFF);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midconv_rst_ready got=%b exp=1", in_ready); end
    rst     = 1'b0;
    in_data = 24'h000012;
    in_dec  = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_accept got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (seg_out !== 48'hC0C0_C0C0_F9A4) begin
      n_fail++; $display("FAIL post_rst_seg got=%h exp=%h", seg_out, 48'hC0C0_C0C0_F9A4);
    end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL post_rst_ovf got=%b exp=0", overflow); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_dec      = 1'b0;
    in_blank_lz = 1'b0;
    in_dots     = '0;
    blink_en    = 1'b0;
    test_reset();
    test_hex_beef();
    test_dec_123456();
    test_dec_overflow();
    test_dec_boundary();
    test_hex_blank();
    test_blink(48'hFF7F_FFFF_88C0);
    test_reset_mid_conv();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
